ram_arbiter_2to1: RTL and testbench
===================================

Name: ram_arbiter_2to1

Overview:
- Two-master arbiter sharing one single-port, 4096-word, byte-enabled RAM.
- Master 0 is the instruction-fetch port (read-only); master 1 is the data port (read/write).
- The RAM behind it has a 1-cycle registered read latency.
- The arbiter sequences each access as ISSUE then ACK, grants round-robin under contention, and gives each master Avalon-style waitrequest handshaking.

Parameters:
- ADDR_LSB, 2, byte-address bit mapped to RAM word-address bit 0.
- RAM_AW, 12, RAM word-address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m0_address  in  32  master 0 byte address
- m0_read  in  1  master 0 read request
- m0_waitrequest  out  1  high = master 0 must hold request
- m0_readdata  out  32  master 0 read data, valid when m0_read && !m0_waitrequest
- m1_address  in  32  master 1 byte address
- m1_read  in  1  master 1 read request
- m1_write  in  1  master 1 write request
- m1_byteenable  in  4  master 1 byte lanes
- m1_writedata  in  32  master 1 write data
- m1_waitrequest  out  1  high = master 1 must hold request
- m1_readdata  out  32  master 1 read data
- ram_address  out  RAM_AW  RAM word address
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_byteenable  out  4  RAM byte lanes
- ram_writedata  out  32  RAM write data
- ram_readdata  in  32  RAM registered read data

Behaviour:
- State machine: IDLE, ACK. Registers: state, grant (1 bit), last_grant (1 bit).
- Reset: state=IDLE, last_grant=1 (so master 0 wins the first tie), grant=0.
  - While reset is high: ram_read=0, ram_write=0, both waitrequest=1, ram_byteenable=0.
- req0 = m0_read. req1 = m1_read | m1_write.
- IDLE, no request: ram strobes 0; ram_address=0; ram_byteenable=0; stay in IDLE.
- IDLE, one or both requests:
  - Winner: the sole requester; on a tie, !last_grant.
  - In the same cycle (combinationally) drive the winner's address bits [ADDR_LSB+RAM_AW-1:ADDR_LSB] onto ram_address.
  - Winner m0: ram_read=1, ram_byteenable=4'hF.
  - Winner m1: ram_write=m1_write, ram_read=!m1_write, byteenable and writedata from m1.
  - Register grant=winner and last_grant=winner; go to ACK.
- ACK:
  - ram_read=0, ram_write=0.
  - Granted master sees waitrequest=0; the other sees waitrequest=1.
  - Return to IDLE next cycle.
- waitrequest is combinational: waitrequest_i = !(state==ACK && grant==i && !reset). Both masters are waitrequest=1 in IDLE.
- m0_readdata and m1_readdata are both wired to ram_readdata. Data is only meaningful in the granted master's ACK cycle.
- Latency and throughput:
  - Each access completes 1 cycle after issue, i.e. request seen in cycle N gives waitrequest low in N+1.
  - Sustained throughput is 1 access per 2 cycles.
  - Under continuous contention grants alternate m0, m1, m0, …
- The master must hold address, strobes and data stable until its waitrequest-low cycle.
  - If it drops its request while in ACK, ACK still completes. The write has already been performed at issue.
- m1_read && m1_write together: treated as a write; m1_readdata is undefined for that access.
- Address bits outside the mapped window are ignored, so addresses alias modulo 4096 words.
- Reset asserted during ACK: the access is aborted with no ack. A write issued in the previous cycle has already landed in RAM.

Decomposition:
- Shared package (mem_pkg):
  - typedef arb_state_t {IDLE, ACK}
  - constant RAM_WORDS=4096
  - word-address extraction function
- Sub-module rr_picker_2: combinational 2-way round-robin winner from req0, req1 and last_grant. The FSM and mux stay in the top module.

Test Plan:
- m0 reads 0x0000_0010 (RAM word 4 = 0xDEADBEEF):
  - Cycle 0: ram_read=1, ram_address=4.
  - Cycle 1: m0_waitrequest=0, m0_readdata=0xDEADBEEF.
- m1 writes 0x1122_3344 to 0x20 with byteenable=4'b0011, then reads 0x20 (word initially 0xAAAA_AAAA):
  - Write is acked in cycle 1.
  - Read data returns the word with byte lanes 0 and 1 updated per the RAM's lane mapping; the other lanes are unchanged.
- Both masters request continuously for 8 cycles from reset:
  - Acks go to m0, m1, m0, m1, one every 2 cycles.
  - The non-granted master's waitrequest is never low.
- m1 asserts read and write together at 0x40 with writedata 0x5:
  - The RAM is written (word 16 = 5).
  - m1 is acked after 1 cycle.
- Reset pulsed in the ACK cycle of an m0 read:
  - No waitrequest-low cycle occurs.
  - Next cycle state is IDLE and both waitrequest are 1.
  - A subsequent tie grants m0 first.
- m0 reads 0x0000_4010 (aliased):
  - ram_address=4.
  - Same data as for address 0x10.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the two-master RAM arbiter.
package mem_pkg;

    // Arbiter sequencing: IDLE issues an access, ACK releases the winner.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } arb_state_t;

    localparam int RAM_WORDS = 4096;

    // Byte address to word index; the caller truncates to the RAM width,
    // so any bits above the RAM window simply alias.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input int unsigned lsb);
        return byte_addr >> lsb;
    endfunction

endpackage

// File: rtl/ram_arbiter_2to1_if.sv
// Bundle of both master ports and the shared RAM port.
interface ram_arbiter_2to1_if #(
    parameter int RAM_AW = 12
) ();
    // Master 0: instruction fetch, read-only
    logic [31:0]       m0_address;
    logic              m0_read;
    logic              m0_waitrequest;
    logic [31:0]       m0_readdata;

    // Master 1: data port, read/write
    logic [31:0]       m1_address;
    logic              m1_read;
    logic              m1_write;
    logic [3:0]        m1_byteenable;
    logic [31:0]       m1_writedata;
    logic              m1_waitrequest;
    logic [31:0]       m1_readdata;

    // Shared single-port RAM
    logic [RAM_AW-1:0] ram_address;
    logic              ram_read;
    logic              ram_write;
    logic [3:0]        ram_byteenable;
    logic [31:0]       ram_writedata;
    logic [31:0]       ram_readdata;

    // Arbiter side
    modport slave (
        input  m0_address, m0_read,
        output m0_waitrequest, m0_readdata,
        input  m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
        output m1_waitrequest, m1_readdata,
        output ram_address, ram_read, ram_write, ram_byteenable, ram_writedata,
        input  ram_readdata
    );

    // Environment side: the two masters plus the RAM itself
    modport master (
        output m0_address, m0_read,
        input  m0_waitrequest, m0_readdata,
        output m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
        input  m1_waitrequest, m1_readdata,
        input  ram_address, ram_read, ram_write, ram_byteenable, ram_writedata,
        output ram_readdata
    );
endinterface

// File: rtl/ram_arbiter_2to1_rr_picker_2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// a tie goes to whichever master did not win last time.
module rr_picker_2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic any_req,
    output logic winner
);
    // Winner selection
    always_comb begin
        any_req = req0 | req1;
        winner  = 1'b0;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = 1'b1;
        end
    end
endmodule

// File: rtl/ram_arbiter_2to1.sv
// Two-master arbiter in front of a single-port byte-enabled RAM with a
// registered read. Every access takes an ISSUE cycle (IDLE with a request)
// followed by an ACK cycle in which the winner's waitrequest drops.
module ram_arbiter_2to1
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_LSB = 2,
    parameter int unsigned RAM_AW   = 12
) (
    input logic              clk,
    input logic              reset,
    ram_arbiter_2to1_if.slave bus
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              grant;
    logic              last_grant;

    logic              req0;
    logic              req1;
    logic              any_req;
    logic              winner;
    logic              issue;

    logic [RAM_AW-1:0] ram_address;
    logic              ram_read;
    logic              ram_write;
    logic [3:0]        ram_byteenable;
    logic [31:0]       ram_writedata;

    // A simultaneous read+write on master 1 still counts as one request.
    assign req0 = bus.m0_read;
    assign req1 = bus.m1_read | bus.m1_write;

    rr_picker_2 u_picker (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .any_req    (any_req),
        .winner     (winner)
    );

    // State, grant and round-robin history
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (issue) begin
                grant      <= winner;
                last_grant <= winner;
            end
        end
    end

    // Next state and RAM command; the command is driven in the issue cycle
    // itself so the registered read data lines up with the ACK cycle.
    always_comb begin
        state_next     = state;
        issue          = 1'b0;
        ram_address    = '0;
        ram_read       = 1'b0;
        ram_write      = 1'b0;
        ram_byteenable = 4'h0;
        ram_writedata  = 32'h0;
        case (state)
            IDLE: begin
                if (any_req && !reset) begin
                    issue      = 1'b1;
                    state_next = ACK;
                    if (!winner) begin
                        ram_address    = RAM_AW'(word_index(bus.m0_address, ADDR_LSB));
                        ram_read       = 1'b1;
                        ram_byteenable = 4'hF;
                    end else begin
                        // Write takes priority when both strobes are high.
                        ram_address    = RAM_AW'(word_index(bus.m1_address, ADDR_LSB));
                        ram_write      = bus.m1_write;
                        ram_read       = ~bus.m1_write;
                        ram_byteenable = bus.m1_byteenable;
                        ram_writedata  = bus.m1_writedata;
                    end
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs; reset during ACK suppresses the acknowledge.
    always_comb begin
        bus.m0_waitrequest = ~((state == ACK) && (grant == 1'b0) && !reset);
        bus.m1_waitrequest = ~((state == ACK) && (grant == 1'b1) && !reset);
        bus.m0_readdata    = bus.ram_readdata;
        bus.m1_readdata    = bus.ram_readdata;
        bus.ram_address    = ram_address;
        bus.ram_read       = ram_read;
        bus.ram_write      = ram_write;
        bus.ram_byteenable = ram_byteenable;
        bus.ram_writedata  = ram_writedata;
    end

endmodule

// File: tb/tb_ram_arbiter_2to1.sv
// Directed bench for ram_arbiter_2to1 with a byte-lane RAM model
// (lane i = bits [8i+7:8i], one-cycle registered read).
module tb_ram_arbiter_2to1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [0:4095];

    ram_arbiter_2to1_if #(.RAM_AW(12)) bus ();

    ram_arbiter_2to1 #(.ADDR_LSB(2), .RAM_AW(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM model
    always @(posedge clk) begin
        if (bus.ram_write) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.ram_byteenable[i]) mem[bus.ram_address][8*i +: 8] <= bus.ram_writedata[8*i +: 8];
            end
        end
        if (bus.ram_read) bus.ram_readdata <= mem[bus.ram_address];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.m0_address    = 32'h0;
        bus.m0_read       = 1'b0;
        bus.m1_address    = 32'h0;
        bus.m1_read       = 1'b0;
        bus.m1_write      = 1'b0;
        bus.m1_byteenable = 4'h0;
        bus.m1_writedata  = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_reqs();
        bus.m0_read = 1'b1;
        bus.m1_write = 1'b1;
        bus.m1_byteenable = 4'hF;
        @(negedge clk);
        checks++;
        if (bus.ram_read !== 1'b0 || bus.ram_write !== 1'b0) begin
            errors++; $display("FAIL reset_strobes rd=%b wr=%b expected 0 0", bus.ram_read, bus.ram_write);
        end
        checks++;
        if (bus.m0_waitrequest !== 1'b1 || bus.m1_waitrequest !== 1'b1) begin
            errors++; $display("FAIL reset_wait w0=%b w1=%b expected 1 1", bus.m0_waitrequest, bus.m1_waitrequest);
        end
        checks++;
        if (bus.ram_byteenable !== 4'h0) begin
            errors++; $display("FAIL reset_be got %h expected 0", bus.ram_byteenable);
        end
        tick();
        tick();
        reset = 1'b0;
        clear_reqs();
        @(negedge clk);
        checks++;
        if (bus.m0_waitrequest !== 1'b1 || bus.m1_waitrequest !== 1'b1 || bus.ram_read !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset w0=%b w1=%b rd=%b expected 1 1 0",
                               bus.m0_waitrequest, bus.m1_waitrequest, bus.ram_read);
        end
        tick();
    endtask

    task automatic test_m0_read();
        bus.m0_address = 32'h0000_0010;
        bus.m0_read    = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ram_read !== 1'b1 || bus.ram_address !== 12'd4 || bus.ram_byteenable !== 4'hF) begin
            errors++; $display("FAIL m0_issue rd=%b addr=%0d be=%h expected 1 4 f",
                               bus.ram_read, bus.ram_address, bus.ram_byteenable);
        end
        checks++;
        if (bus.m0_waitrequest !== 1'b1) begin
            errors++; $display("FAIL m0_issue_wait got %b expected 1", bus.m0_waitrequest);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.m0_waitrequest !== 1'b0 || bus.m1_waitrequest !== 1'b1) begin
            errors++; $display("FAIL m0_ack_wait w0=%b w1=%b expected 0 1", bus.m0_waitrequest, bus.m1_waitrequest);
        end
        checks++;
        if (bus.m0_readdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL m0_readdata got %h expected deadbeef", bus.m0_readdata);
        end
        checks++;
        if (bus.ram_read !== 1'b0) begin
            errors++; $display("FAIL m0_ack_rd got %b expected 0", bus.ram_read);
        end
        tick();
        clear_reqs();
    endtask

    task automatic test_m1_write_read();
        bus.m1_address    = 32'h0000_0020;
        bus.m1_write      = 1'b1;
        bus.m1_byteenable = 4'b0011;
        bus.m1_writedata  = 32'h1122_3344;
        @(negedge clk);
        checks++;
        if (bus.ram_write !== 1'b1 || bus.ram_read !== 1'b0 || bus.ram_address !== 12'd8 ||
            bus.ram_byteenable !== 4'b0011 || bus.ram_writedata !== 32'h1122_3344) begin
            errors++; $display("FAIL m1_write_issue wr=%b rd=%b addr=%0d be=%h wd=%h expected 1 0 8 3 11223344",
                               bus.ram_write, bus.ram_read, bus.ram_address, bus.ram_byteenable, bus.ram_writedata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.m1_waitrequest !== 1'b0 || bus.m0_waitrequest !== 1'b1) begin
            errors++; $display("FAIL m1_write_ack w1=%b w0=%b expected 0 1", bus.m1_waitrequest, bus.m0_waitrequest);
        end
        checks++;
        if (bus.ram_write !== 1'b0) begin
            errors++; $display("FAIL m1_ack_wr got %b expected 0", bus.ram_write);
        end
        tick();
        bus.m1_write = 1'b0;
        bus.m1_read  = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ram_read !== 1'b1 || bus.ram_write !== 1'b0 || bus.ram_address !== 12'd8) begin
            errors++; $display("FAIL m1_read_issue rd=%b wr=%b addr=%0d expected 1 0 8",
                               bus.ram_read, bus.ram_write, bus.ram_address);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.m1_waitrequest !== 1'b0 || bus.m1_readdata !== 32'hAAAA_3344) begin
            errors++; $display("FAIL m1_readback w1=%b data=%h expected 0 aaaa3344", bus.m1_waitrequest, bus.m1_readdata);
        end
        tick();
        clear_reqs();
    endtask

    task automatic test_contention();
        // cycle:            0  1  2  3  4  5  6  7
        logic [7:0] exp_w0 = 8'b1101_1101; // bit k = cycle k
        logic [7:0] exp_w1 = 8'b0111_0111;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.m0_address = 32'h0000_0010;
        bus.m0_read    = 1'b1;
        bus.m1_address = 32'h0000_0020;
        bus.m1_read    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus.m0_waitrequest !== exp_w0[k] || bus.m1_waitrequest !== exp_w1[k]) begin
                errors++; $display("FAIL contention_wait cycle %0d w0=%b w1=%b expected %b %b",
                                   k, bus.m0_waitrequest, bus.m1_waitrequest, exp_w0[k], exp_w1[k]);
            end
            if (k == 0 || k == 4) begin
                checks++;
                if (bus.ram_address !== 12'd4) begin
                    errors++; $display("FAIL contention_addr cycle %0d got %0d expected 4", k, bus.ram_address);
                end
            end
            if (k == 2 || k == 6) begin
                checks++;
                if (bus.ram_address !== 12'd8) begin
                    errors++; $display("FAIL contention_addr cycle %0d got %0d expected 8", k, bus.ram_address);
                end
            end
            if (k == 1 || k == 5) begin
                checks++;
                if (bus.m0_readdata !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL contention_m0_data cycle %0d got %h expected deadbeef", k, bus.m0_readdata);
                end
            end
            if (k == 3 || k == 7) begin
                checks++;
                if (bus.m1_readdata !== 32'hAAAA_3344) begin
                    errors++; $display("FAIL contention_m1_data cycle %0d got %h expected aaaa3344", k, bus.m1_readdata);
                end
            end
            tick();
        end
        clear_reqs();
    endtask

    task automatic test_rw_both();
        bus.m1_address    = 32'h0000_0040;
        bus.m1_read       = 1'b1;
        bus.m1_write      = 1'b1;
        bus.m1_byteenable = 4'hF;
        bus.m1_writedata  = 32'h0000_0005;
        @(negedge clk);
        checks++;
        if (bus.ram_write !== 1'b1 || bus.ram_read !== 1'b0 || bus.ram_address !== 12'd16) begin
            errors++; $display("FAIL rw_issue wr=%b rd=%b addr=%0d expected 1 0 16",
                               bus.ram_write, bus.ram_read, bus.ram_address);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.m1_waitrequest !== 1'b0) begin
            errors++; $display("FAIL rw_ack got %b expected 0", bus.m1_waitrequest);
        end
        checks++;
        if (mem[16] !== 32'h0000_0005) begin
            errors++; $display("FAIL rw_ram_word got %h expected 00000005", mem[16]);
        end
        tick();
        clear_reqs();
    endtask

    task automatic test_reset_in_ack();
        bus.m0_address = 32'h0000_0010;
        bus.m0_read    = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ram_read !== 1'b1) begin
            errors++; $display("FAIL rst_ack_issue rd=%b expected 1", bus.ram_read);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.m0_waitrequest !== 1'b1 || bus.m1_waitrequest !== 1'b1) begin
            errors++; $display("FAIL rst_ack_suppressed w0=%b w1=%b expected 1 1", bus.m0_waitrequest, bus.m1_waitrequest);
        end
        tick();
        reset = 1'b0;
        bus.m1_address = 32'h0000_0020;
        bus.m1_read    = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.m0_waitrequest !== 1'b1 || bus.m1_waitrequest !== 1'b1) begin
            errors++; $display("FAIL rst_idle_wait w0=%b w1=%b expected 1 1", bus.m0_waitrequest, bus.m1_waitrequest);
        end
        checks++;
        if (bus.ram_read !== 1'b1 || bus.ram_address !== 12'd4) begin
            errors++; $display("FAIL rst_tie_pick rd=%b addr=%0d expected 1 4", bus.ram_read, bus.ram_address);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.m0_waitrequest !== 1'b0 || bus.m1_waitrequest !== 1'b1) begin
            errors++; $display("FAIL rst_tie_ack w0=%b w1=%b expected 0 1", bus.m0_waitrequest, bus.m1_waitrequest);
        end
        tick();
        clear_reqs();
    endtask

    task automatic test_alias();
        bus.m0_address = 32'h0000_4010;
        bus.m0_read    = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ram_address !== 12'd4) begin
            errors++; $display("FAIL alias_addr got %0d expected 4", bus.ram_address);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.m0_waitrequest !== 1'b0 || bus.m0_readdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL alias_data w0=%b data=%h expected 0 deadbeef", bus.m0_waitrequest, bus.m0_readdata);
        end
        tick();
        clear_reqs();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'hAAAA_AAAA;
        bus.ram_readdata = 32'h0;
        test_reset();
        test_m0_read();
        test_m1_write_read();
        test_contention();
        test_rw_both();
        test_reset_in_ack();
        test_alias();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
